// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - Iterative AES-128 inverse cipher, one inverse round per clock.
// Optional zeroize port and logic enabled by AES_INV_CIPHER_ZEROIZE_EN.

module aes_inv_sub_bytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine first, then the field inverse computed as y^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y;
    logic [7:0] p;
    logic [7:0] r;
    y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    p = y;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[8*i +: 8] = inv_sbox(data_i[8*i +: 8]);
  end
endmodule

module aes_inv_mix_column (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a, x2, x4, x8, m9, mb, md, me;

  for (genvar i = 0; i < 4; i++) begin : g_row
    assign a[i]  = col_i[31-8*i -: 8];
    assign x2[i] = xt(a[i]);
    assign x4[i] = xt(x2[i]);
    assign x8[i] = xt(x4[i]);
    assign m9[i] = x8[i] ^ a[i];
    assign mb[i] = x8[i] ^ x2[i] ^ a[i];
    assign md[i] = x8[i] ^ x4[i] ^ a[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
    assign col_o[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
  end
endmodule

module aes_inv_cipher (
  input  logic         i_aes_inv_cipher_clk,
  input  logic         i_aes_inv_cipher_rst_n,
  input  logic         i_aes_inv_cipher_key_we,
  input  logic [3:0]   i_aes_inv_cipher_key_idx,
  input  logic [127:0] i_aes_inv_cipher_key_data,
  input  logic         i_aes_inv_cipher_valid,
  output logic         o_aes_inv_cipher_ready,
  input  logic [127:0] i_aes_inv_cipher_data_in,
  output logic         o_aes_inv_cipher_valid,
  input  logic         i_aes_inv_cipher_ready,
  output logic [127:0] o_aes_inv_cipher_data_out
`ifdef AES_INV_CIPHER_ZEROIZE_EN
  ,
  input  logic         i_aes_inv_cipher_zeroize
`endif
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] key_q [0:10];
  logic [127:0] key_d [0:10];
  logic [127:0] sr_w, sb_w, ark_w, mc_w;

  // InvShiftRows: row r rotates right by r byte positions.
  for (genvar r = 0; r < 4; r++) begin : g_sr_row
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
      assign sr_w[127-8*(r+4*c) -: 8] = state_q[127-8*(r+4*((c-r+4)%4)) -: 8];
    end
  end

  aes_inv_sub_bytes u_inv_sub_bytes (.data_i(sr_w), .data_o(sb_w));

  assign ark_w = sb_w ^ key_q[rnd_q];

  for (genvar c = 0; c < 4; c++) begin : g_mc
    aes_inv_mix_column u_inv_mix_column (
      .col_i(ark_w[127-32*c -: 32]),
      .col_o(mc_w[127-32*c -: 32])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    for (int k = 0; k < 11; k++) key_d[k] = key_q[k];

    case (fsm_q)
      IDLE: begin
        if (i_aes_inv_cipher_key_we && (i_aes_inv_cipher_key_idx <= 4'd10))
          key_d[i_aes_inv_cipher_key_idx] = i_aes_inv_cipher_key_data;
        if (i_aes_inv_cipher_valid) begin
          state_d = i_aes_inv_cipher_data_in ^ key_q[10];
          rnd_d   = 4'd9;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q == 4'd0) begin
          state_d = ark_w;
          fsm_d   = DONE;
        end else begin
          state_d = mc_w;
          rnd_d   = rnd_q - 4'd1;
        end
      end
      DONE: begin
        if (i_aes_inv_cipher_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

`ifdef AES_INV_CIPHER_ZEROIZE_EN
    if (i_aes_inv_cipher_zeroize) begin
      fsm_d   = IDLE;
      state_d = '0;
      rnd_d   = '0;
      for (int k = 0; k < 11; k++) key_d[k] = '0;
    end
`endif
  end

  always_ff @(posedge i_aes_inv_cipher_clk or negedge i_aes_inv_cipher_rst_n) begin
    if (!i_aes_inv_cipher_rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      for (int k = 0; k < 11; k++) key_q[k] <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      for (int k = 0; k < 11; k++) key_q[k] <= key_d[k];
    end
  end

  assign o_aes_inv_cipher_ready    = (fsm_q == IDLE);
  assign o_aes_inv_cipher_valid    = (fsm_q == DONE);
  assign o_aes_inv_cipher_data_out = state_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb/tb_aes_inv_cipher.sv - Self-checking bench for aes_inv_cipher against a table-based AES model.
module tb_aes_inv_cipher;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_we = 1'b0;
  logic [3:0]   key_idx = 4'd0;
  logic [127:0] key_data = '0;
  logic         vin = 1'b0;
  logic [127:0] data_in = '0;
  logic         rdy_in = 1'b1;
  logic         ready_o;
  logic         valid_o;
  logic [127:0] dout;
`ifdef AES_INV_CIPHER_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  aes_inv_cipher dut (
    .i_aes_inv_cipher_clk      (clk),
    .i_aes_inv_cipher_rst_n    (rst_n),
    .i_aes_inv_cipher_key_we   (key_we),
    .i_aes_inv_cipher_key_idx  (key_idx),
    .i_aes_inv_cipher_key_data (key_data),
    .i_aes_inv_cipher_valid    (vin),
    .o_aes_inv_cipher_ready    (ready_o),
    .i_aes_inv_cipher_data_in  (data_in),
    .o_aes_inv_cipher_valid    (valid_o),
    .i_aes_inv_cipher_ready    (rdy_in),
    .o_aes_inv_cipher_data_out (dout)
`ifdef AES_INV_CIPHER_ZEROIZE_EN
    ,
    .i_aes_inv_cipher_zeroize  (zeroize)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic chk128(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  // Reference model: log/antilog field arithmetic, S-box tables and textbook InvCipher.
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [7:0]   gexp  [256];
  int           glog  [256];
  logic [7:0]   imc   [4];
  logic [127:0] mk    [11];

  function automatic logic [7:0] xt8(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < k; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] v;
    logic [7:0] inv;
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = v;
      glog[v] = i;
      v = v ^ xt8(v);
    end
    gexp[255] = gexp[0];
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : gexp[(255 - glog[x]) % 255];
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      isbox[sbox[x]] = x[7:0];
    end
    imc[0] = 8'h0e; imc[1] = 8'h0b; imc[2] = 8'h0d; imc[3] = 8'h09;
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc = xt8(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ mk[10][127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) t[rr+4*((c+rr)%4)] = s[rr+4*c];
      for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ mk[r][127-8*i -: 8];
      if (r > 0) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) begin
            s[rr+4*c] = 8'h00;
            for (int j = 0; j < 4; j++) s[rr+4*c] = s[rr+4*c] ^ gmul(imc[(j-rr+4)%4], t[j+4*c]);
          end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (!ready_o && t < 50) begin @(negedge clk); t++; end
  endtask

  task automatic load_keys(input logic [127:0] key);
    expand(key);
    wait_idle();
    for (int r = 0; r < 11; r++) begin
      key_we = 1'b1; key_idx = r[3:0]; key_data = mk[r];
      @(negedge clk);
    end
    key_we = 1'b0;
  endtask

  // hook 1: write key[5]=0 mid-round; hook 3: write key[10]=alt on the accept edge.
  task automatic run_block(input logic [127:0] ct, input int hook, input logic [127:0] alt,
                           output logic [127:0] pt, output int lat);
    wait_idle();
    data_in = ct; vin = 1'b1;
    if (hook == 3) begin key_we = 1'b1; key_idx = 4'd10; key_data = alt; end
    @(negedge clk);
    vin = 1'b0; key_we = 1'b0;
    lat = 0;
    while (!valid_o && lat < 40) begin
      if (hook == 1 && lat == 3) begin key_we = 1'b1; key_idx = 4'd5; key_data = '0; end
      @(negedge clk);
      key_we = 1'b0;
      lat++;
    end
    pt = dout;
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    vec_t         tbl [6];
    logic [127:0] got, alt, ctb, expb;
    logic [127:0] outs [2];
    int           acc [3];
    int           lat, ok, nacc, nout;

    build_tables();
    tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
               128'h3243f6a8885a308d313198a2e0370734};
    tbl[1] = '{C1_KEY, C1_CT, C1_PT};
    for (int i = 2; i < 6; i++) begin
      tbl[i].key = rand128();
      tbl[i].ct  = rand128();
      expand(tbl[i].key);
      tbl[i].pt  = ref_decrypt(tbl[i].ct);
    end

    repeat (3) @(negedge clk);
    chk_int("reset_ready", int'(ready_o), 1);
    chk_int("reset_valid", int'(valid_o), 0);
    chk128("reset_data_out", dout, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      load_keys(tbl[i].key);
      run_block(tbl[i].ct, 0, '0, got, lat);
      chk128($sformatf("vec%0d_pt", i), got, tbl[i].pt);
      chk_int($sformatf("vec%0d_latency", i), lat, 10);
    end

    // Backpressure: output held for 20 cycles, then release.
    load_keys(C1_KEY);
    rdy_in = 1'b0;
    run_block(C1_CT, 0, '0, got, lat);
    chk128("bp_pt", got, C1_PT);
    chk_int("bp_latency", lat, 10);
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!valid_o || ready_o || dout !== C1_PT) ok = 0;
    end
    chk_int("bp_hold", ok, 1);
    rdy_in = 1'b1;
    @(negedge clk);
    chk_int("bp_release_ready", int'(ready_o), 1);
    chk_int("bp_release_valid", int'(valid_o), 0);

    // Key write while busy, then out-of-range index in IDLE.
    run_block(C1_CT, 1, '0, got, lat);
    chk128("busy_write_pt", got, C1_PT);
    wait_idle();
    key_we = 1'b1; key_idx = 4'd12; key_data = rand128();
    @(negedge clk);
    key_we = 1'b0;
    run_block(C1_CT, 0, '0, got, lat);
    chk128("bad_idx_rerun_pt", got, C1_PT);

    // Same-edge key[10] write with accept: this block whitens with the old key.
    alt = rand128();
    run_block(C1_CT, 3, alt, got, lat);
    chk128("same_edge_write_pt", got, C1_PT);
    mk[10] = alt;
    expb = ref_decrypt(C1_CT);
    run_block(C1_CT, 0, '0, got, lat);
    chk128("after_same_edge_pt", got, expb);

    // Back-to-back with valid held high.
    load_keys(C1_KEY);
    ctb  = rand128();
    expb = ref_decrypt(ctb);
    wait_idle();
    nacc = 0; nout = 0;
    outs[0] = '0; outs[1] = '0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    data_in = C1_CT; vin = 1'b1;
    for (int t = 0; t < 80 && nout < 2; t++) begin
      if (valid_o) begin outs[nout] = dout; nout++; end
      if (ready_o && vin) begin acc[nacc] = cyc; nacc++; end
      @(negedge clk);
      if (nacc == 1) data_in = ctb;
      else if (nacc >= 2) vin = 1'b0;
    end
    vin = 1'b0;
    chk128("b2b_first_pt", outs[0], C1_PT);
    chk128("b2b_second_pt", outs[1], expb);
    chk_int("b2b_accept_spacing", acc[1] - acc[0], 12);

    // Reset mid-round, then decrypt with the cleared key store.
    wait_idle();
    data_in = C1_CT; vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_int("midreset_valid", int'(valid_o), 0);
    chk_int("midreset_ready", int'(ready_o), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 11; r++) mk[r] = '0;
    expb = ref_decrypt('0);
    run_block('0, 0, '0, got, lat);
    chk128("zero_key_pt", got, expb);
    chk_int("zero_key_latency", lat, 10);

`ifdef AES_INV_CIPHER_ZEROIZE_EN
    load_keys(C1_KEY);
    rdy_in = 1'b0;
    run_block(C1_CT, 0, '0, got, lat);
    chk128("zeroize_pre_pt", got, C1_PT);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    chk_int("zeroize_valid", int'(valid_o), 0);
    chk_int("zeroize_ready", int'(ready_o), 1);
    chk128("zeroize_data_out", dout, '0);
    rdy_in = 1'b1;
    for (int r = 0; r < 11; r++) mk[r] = '0;
    expb = ref_decrypt('0);
    run_block('0, 0, '0, got, lat);
    chk128("zeroize_zero_key_pt", got, expb);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", nerr, nchk);
    $fatal(1);
  end
endmodule
